// File: rtl/exec_sequencer.sv
// Multi-cycle issue controller: classifies each issued op, stalls the pipeline for its latency,
// sequences UART IN/OUT against the RX/TX rings and keeps a saturating stall-cycle counter.
module exec_sequencer #(
  parameter int unsigned CNT_W    = 4,
  parameter int unsigned LAT_LW   = 1,
  parameter int unsigned LAT_MUL  = 2,
  parameter int unsigned LAT_SLOW = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [1:0]  op_type,
  input  logic [5:0]  instr,
  input  logic        rx_empty,
  input  logic [7:0]  rx_data,
  input  logic        tx_full,
  output logic        busy,
  output logic        done,
  output logic        rx_pop,
  output logic        tx_push,
  output logic [31:0] in_data,
  output logic [31:0] stall_cnt
);

  localparam int unsigned LAT_W = CNT_W + 1;

  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_LW_S   = 6'h31;
  localparam logic [5:0] OP_IN     = 6'h3a;
  localparam logic [5:0] OP_OUT    = 6'h3b;
  localparam logic [5:0] FUNC_MULT = 6'h18;
  localparam logic [5:0] FUNC_DIV  = 6'h1a;
  localparam logic [5:0] FPU_ADD   = 6'h00;
  localparam logic [5:0] FPU_SUB   = 6'h01;
  localparam logic [5:0] FPU_MUL   = 6'h02;
  localparam logic [5:0] FPU_INV   = 6'h03;
  localparam logic [5:0] FPU_SQRT  = 6'h04;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WAIT     = 3'd1;
  localparam logic [2:0] S_IN_WAIT  = 3'd2;
  localparam logic [2:0] S_IN_DONE  = 3'd3;
  localparam logic [2:0] S_OUT_WAIT = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       in_byte_q, in_byte_d;
  logic [31:0]      stall_cnt_q, stall_cnt_d;
  logic [LAT_W-1:0] lat;
  logic             is_in, is_out;

  // Latency class of the op currently presented on op_type/instr
  always_comb begin
    lat    = '0;
    is_in  = 1'b0;
    is_out = 1'b0;
    case (op_type)
      2'b00: begin
        case (instr)
          OP_LW, OP_LW_S: lat = LAT_W'(LAT_LW);
          OP_IN:          is_in = 1'b1;
          OP_OUT:         is_out = 1'b1;
          default:        lat = '0;
        endcase
      end
      2'b01: begin
        case (instr)
          FUNC_MULT: lat = LAT_W'(LAT_MUL);
          FUNC_DIV:  lat = LAT_W'(LAT_SLOW);
          default:   lat = '0;
        endcase
      end
      2'b10: begin
        case (instr)
          FPU_ADD, FPU_SUB, FPU_MUL: lat = LAT_W'(LAT_MUL);
          FPU_INV, FPU_SQRT:         lat = LAT_W'(LAT_SLOW);
          default:                   lat = '0;
        endcase
      end
      default: lat = '0;
    endcase
  end

  // Next state and handshake outputs; rst and abort suppress every strobe
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    in_byte_d = in_byte_q;
    busy      = 1'b0;
    done      = 1'b0;
    rx_pop    = 1'b0;
    tx_push   = 1'b0;
    if (rst || abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (is_in) begin
              busy    = 1'b1;
              state_d = S_IN_WAIT;
            end else if (is_out) begin
              if (tx_full) begin
                busy    = 1'b1;
                state_d = S_OUT_WAIT;
              end else begin
                tx_push = 1'b1;
                done    = 1'b1;
              end
            end else if (lat != '0) begin
              busy    = 1'b1;
              cnt_d   = CNT_W'(lat - LAT_W'(1));
              state_d = S_WAIT;
            end else begin
              done = 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q != '0) begin
            busy  = 1'b1;
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            done    = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_IN_WAIT: begin
          busy = 1'b1;
          if (!rx_empty) begin
            rx_pop    = 1'b1;
            in_byte_d = rx_data;
            state_d   = S_IN_DONE;
          end
        end
        S_IN_DONE: begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
        S_OUT_WAIT: begin
          if (tx_full) begin
            busy = 1'b1;
          end else begin
            tx_push = 1'b1;
            done    = 1'b1;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Saturating stall counter
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (busy && (stall_cnt_q != 32'hffff_ffff)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      in_byte_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_byte_q   <= in_byte_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign in_data   = {24'b0, in_byte_q};
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Bench for exec_sequencer: directed scenarios plus random traffic, all checked every cycle
// against a cycle-count based behavioural model.
module tb_exec_sequencer;

  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_LW_S   = 6'h31;
  localparam logic [5:0] OP_IN     = 6'h3a;
  localparam logic [5:0] OP_OUT    = 6'h3b;
  localparam logic [5:0] FUNC_ADD  = 6'h20;
  localparam logic [5:0] FUNC_MULT = 6'h18;
  localparam logic [5:0] FUNC_DIV  = 6'h1a;
  localparam logic [5:0] FPU_ADD   = 6'h00;
  localparam logic [5:0] FPU_SUB   = 6'h01;
  localparam logic [5:0] FPU_MUL   = 6'h02;
  localparam logic [5:0] FPU_INV   = 6'h03;
  localparam logic [5:0] FPU_SQRT  = 6'h04;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, abort, rx_empty, tx_full;
  logic [1:0]  op_type;
  logic [5:0]  instr;
  logic [7:0]  rx_data;
  logic        busy, done, rx_pop, tx_push;
  logic [31:0] in_data, stall_cnt;

  exec_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .op_type(op_type), .instr(instr),
    .rx_empty(rx_empty), .rx_data(rx_data), .tx_full(tx_full), .busy(busy), .done(done),
    .rx_pop(rx_pop), .tx_push(tx_push), .in_data(in_data), .stall_cnt(stall_cnt)
  );

  typedef enum int {K_IDLE, K_LAT, K_INW, K_IND, K_OUTW} kind_t;

  kind_t       m_kind;
  longint      m_cyc, m_done_at;
  logic [7:0]  m_in;
  logic [31:0] m_stall;

  int n_vec = 0;
  int n_err = 0;
  logic o_busy, o_done, o_pop, o_push;
  int c_pop = 0;
  int c_push = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Cycles to completion: -1 = UART IN, -2 = UART OUT
  function automatic int lat_of(input logic [1:0] t, input logic [5:0] i);
    if (t == 2'b00 && (i == OP_LW || i == OP_LW_S)) return 1;
    if (t == 2'b00 && i == OP_IN) return -1;
    if (t == 2'b00 && i == OP_OUT) return -2;
    if (t == 2'b01 && i == FUNC_MULT) return 2;
    if (t == 2'b01 && i == FUNC_DIV) return 4;
    if (t == 2'b10 && (i == FPU_ADD || i == FPU_SUB || i == FPU_MUL)) return 2;
    if (t == 2'b10 && (i == FPU_INV || i == FPU_SQRT)) return 4;
    return 0;
  endfunction

  // One clock: check outputs at the falling edge, advance the model after the rising edge
  task automatic tick();
    logic  e_b, e_d, e_p, e_u;
    kind_t n_kind;
    int    l;
    logic [7:0] n_in;
    @(negedge clk);
    e_b = 1'b0; e_d = 1'b0; e_p = 1'b0; e_u = 1'b0;
    n_kind = m_kind;
    n_in = m_in;
    if (rst || abort) begin
      n_kind = K_IDLE;
    end else begin
      case (m_kind)
        K_IDLE: if (start) begin
          l = lat_of(op_type, instr);
          if (l == -1) begin
            e_b = 1'b1; n_kind = K_INW;
          end else if (l == -2) begin
            if (tx_full) begin e_b = 1'b1; n_kind = K_OUTW; end
            else begin e_u = 1'b1; e_d = 1'b1; end
          end else if (l == 0) begin
            e_d = 1'b1;
          end else begin
            e_b = 1'b1; n_kind = K_LAT; m_done_at = m_cyc + longint'(l);
          end
        end
        K_LAT: if (m_cyc == m_done_at) begin e_d = 1'b1; n_kind = K_IDLE; end
               else e_b = 1'b1;
        K_INW: begin
          e_b = 1'b1;
          if (!rx_empty) begin e_p = 1'b1; n_in = rx_data; n_kind = K_IND; end
        end
        K_IND: begin e_d = 1'b1; n_kind = K_IDLE; end
        K_OUTW: if (tx_full) e_b = 1'b1;
                else begin e_u = 1'b1; e_d = 1'b1; n_kind = K_IDLE; end
        default: n_kind = K_IDLE;
      endcase
    end
    chk("busy", 32'(busy), 32'(e_b));
    chk("done", 32'(done), 32'(e_d));
    chk("rx_pop", 32'(rx_pop), 32'(e_p));
    chk("tx_push", 32'(tx_push), 32'(e_u));
    chk("in_data", in_data, {24'b0, m_in});
    chk("stall_cnt", stall_cnt, m_stall);
    o_busy = busy; o_done = done; o_pop = rx_pop; o_push = tx_push;
    c_pop += int'(rx_pop);
    c_push += int'(tx_push);
    @(posedge clk);
    #1;
    m_kind = n_kind;
    if (rst) begin
      m_in = 8'h00;
      m_stall = 32'h0;
    end else begin
      m_in = n_in;
      if (e_b && m_stall != 32'hffff_ffff) m_stall = m_stall + 32'd1;
    end
    m_cyc++;
  endtask

  task automatic quiet();
    rst = 1'b0; start = 1'b0; abort = 1'b0; op_type = 2'b11; instr = 6'h00;
    rx_empty = 1'b1; rx_data = 8'h00; tx_full = 1'b0;
  endtask

  task automatic issue(input logic [1:0] t, input logic [5:0] i);
    start = 1'b1; op_type = t; instr = i;
  endtask

  task automatic run(input int n, output int nb, output int nd_first, output int ndone);
    nb = 0; nd_first = -1; ndone = 0;
    for (int k = 0; k < n; k++) begin
      tick();
      if (k == 0) start = 1'b0;
      nb += int'(o_busy);
      if (o_done) begin
        ndone++;
        if (nd_first < 0) nd_first = k;
      end
    end
  endtask

  logic [5:0] pool [12];
  int nb, nd, ndn, p0, nbusy;

  initial begin
    pool = '{OP_LW, OP_LW_S, OP_IN, OP_OUT, FUNC_ADD, FUNC_MULT, FUNC_DIV,
             FPU_ADD, FPU_SUB, FPU_MUL, FPU_INV, FPU_SQRT};
    m_kind = K_IDLE; m_cyc = 0; m_done_at = 0; m_in = 8'h00; m_stall = 32'h0;
    quiet();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("reset_stall", stall_cnt, 32'h0);
    chk("reset_in_data", in_data, 32'h0);

    // Basic latencies
    issue(2'b01, FUNC_ADD); run(2, nb, nd, ndn);
    chk("add_done_cycle", 32'(nd), 32'd0);
    chk("add_busy_cycles", 32'(nb), 32'd0);
    issue(2'b00, OP_LW); run(3, nb, nd, ndn);
    chk("lw_done_cycle", 32'(nd), 32'd1);
    chk("lw_busy_cycles", 32'(nb), 32'd1);
    issue(2'b01, FUNC_DIV); run(6, nb, nd, ndn);
    chk("div_done_cycle", 32'(nd), 32'd4);
    chk("div_busy_cycles", 32'(nb), 32'd4);
    chk("stall_after_three", stall_cnt, 32'd5);

    // IN with an empty buffer for 5 cycles
    p0 = c_pop; nbusy = 0; nd = -1;
    issue(2'b00, OP_IN);
    for (int k = 0; k < 8; k++) begin
      rx_empty = (k < 5);
      rx_data = 8'h41;
      tick();
      if (k == 0) start = 1'b0;
      nbusy += int'(o_busy);
      if (o_done && nd < 0) nd = k;
    end
    rx_empty = 1'b1;
    chk("in_pops", 32'(c_pop - p0), 32'd1);
    chk("in_done_cycle", 32'(nd), 32'd6);
    chk("in_busy_cycles", 32'(nbusy), 32'd6);
    chk("in_data_41", in_data, 32'h0000_0041);

    // OUT without and with backpressure
    p0 = c_push;
    issue(2'b00, OP_OUT); run(2, nb, nd, ndn);
    chk("out_free_done", 32'(nd), 32'd0);
    chk("out_free_push", 32'(c_push - p0), 32'd1);
    p0 = c_push; nbusy = 0; nd = -1;
    issue(2'b00, OP_OUT);
    for (int k = 0; k < 6; k++) begin
      tx_full = (k < 3);
      tick();
      if (k == 0) start = 1'b0;
      nbusy += int'(o_busy);
      if (o_done && nd < 0) nd = k;
    end
    chk("out_bp_done", 32'(nd), 32'd3);
    chk("out_bp_busy", 32'(nbusy), 32'd3);
    chk("out_bp_push", 32'(c_push - p0), 32'd1);

    // Abort during SQRT wait
    issue(2'b10, FPU_SQRT); tick(); start = 1'b0; tick();
    abort = 1'b1; tick();
    chk("abort_busy", 32'(o_busy), 32'd0);
    abort = 1'b0;
    run(4, nb, nd, ndn);
    chk("abort_no_done", 32'(ndn), 32'd0);

    // Abort in IN_WAIT while data is available
    issue(2'b00, OP_IN); tick(); start = 1'b0; tick();
    rx_empty = 1'b0; rx_data = 8'h99; abort = 1'b1; tick();
    chk("abort_in_pop", 32'(o_pop), 32'd0);
    abort = 1'b0; rx_empty = 1'b1; tick();
    chk("abort_in_data", in_data, 32'h0000_0041);

    // Reset mid-operation in WAIT and in OUT_WAIT
    issue(2'b01, FUNC_DIV); tick(); start = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_wait_stall", stall_cnt, 32'h0);
    chk("rst_wait_in_data", in_data, 32'h0);
    issue(2'b01, FUNC_ADD); run(2, nb, nd, ndn);
    chk("rst_add_done", 32'(nd), 32'd0);
    tx_full = 1'b1;
    issue(2'b00, OP_OUT); tick(); start = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0; tx_full = 1'b0;
    run(3, nb, nd, ndn);
    chk("rst_out_no_done", 32'(ndn), 32'd0);

    // Start toggled while busy must not re-issue
    op_type = 2'b01; instr = FUNC_DIV; ndn = 0; nbusy = 0;
    for (int k = 0; k < 8; k++) begin
      start = (k == 0 || k == 2 || k == 3);
      tick();
      nbusy += int'(o_busy);
      ndn += int'(o_done);
    end
    start = 1'b0;
    chk("ignored_start_done", 32'(ndn), 32'd1);
    chk("ignored_start_busy", 32'(nbusy), 32'd4);

    // Saturation of the stall counter
    force dut.stall_cnt_q = 32'hffff_fffd;
    #1;
    release dut.stall_cnt_q;
    m_stall = 32'hffff_fffd;
    issue(2'b01, FUNC_DIV); run(6, nb, nd, ndn);
    chk("stall_saturated", stall_cnt, 32'hffff_ffff);

    // Random traffic
    for (int k = 0; k < 4000; k++) begin
      rst      = ($urandom_range(0, 99) == 0);
      abort    = ($urandom_range(0, 19) == 0);
      start    = ($urandom_range(0, 2) == 0);
      op_type  = 2'($urandom_range(0, 3));
      instr    = ($urandom_range(0, 3) == 0) ? 6'($urandom) : pool[$urandom_range(0, 11)];
      rx_empty = ($urandom_range(0, 2) != 0);
      rx_data  = 8'($urandom);
      tx_full  = ($urandom_range(0, 1) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
